// File: rtl/rpn_pkg.sv
// Shared types and default sizing for the RPN operand stack.
package rpn_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/rpn_operand_stack_if.sv
// Operand-stack bus: user push/operator requests, ALU handshake and status.
interface rpn_operand_stack_if
  import rpn_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int DW = $clog2(DEPTH + 1);

  logic             clear_i;
  logic             push_i;
  logic [WIDTH-1:0] data_i;
  logic             op_start_i;
  logic [WIDTH-1:0] operand_a_o;
  logic [WIDTH-1:0] operand_b_o;
  logic             op_req_o;
  logic             res_valid_i;
  logic [WIDTH-1:0] res_i;
  logic [WIDTH-1:0] top_o;
  logic [DW-1:0]    depth_o;
  logic             empty_o;
  logic             full_o;
  logic             busy_o;
  logic             err_o;

  modport master (
    output clear_i, push_i, data_i, op_start_i, res_valid_i, res_i,
    input  operand_a_o, operand_b_o, op_req_o, top_o, depth_o,
           empty_o, full_o, busy_o, err_o
  );

  modport slave (
    input  clear_i, push_i, data_i, op_start_i, res_valid_i, res_i,
    output operand_a_o, operand_b_o, op_req_o, top_o, depth_o,
           empty_o, full_o, busy_o, err_o
  );

endinterface

// File: rtl/rpn_stack_regfile.sv
// DEPTH x WIDTH stack storage: one write port, reads of top and top-1 selected by depth.
module rpn_stack_regfile
  import rpn_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [$clog2(DEPTH+1)-1:0]     wr_idx,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic [$clog2(DEPTH+1)-1:0]     depth,
  output logic [WIDTH-1:0]               top_data,
  output logic [WIDTH-1:0]               next_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage entries, zeroed on reset, written through the single port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && (int'(wr_idx) == i)) mem_r[i] <= wr_data;
      end
    end
  end

  // Read ports; integer compares keep the selects safe for any DEPTH
  always_comb begin
    top_data  = '0;
    next_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(depth) == i + 1) top_data = mem_r[i];
      if (int'(depth) == i + 2) next_data = mem_r[i];
    end
  end

endmodule

// File: rtl/rpn_operand_stack.sv
// RPN operand stack: LIFO of operands, pops two for the ALU and pushes its result back.
module rpn_operand_stack
  import rpn_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  rpn_operand_stack_if.slave  bus
);

  localparam int DW = $clog2(DEPTH + 1);

  state_t           state_r, state_s;
  logic [DW-1:0]    depth_r, depth_s;
  logic [WIDTH-1:0] op_a_r, op_b_r;
  logic             op_req_r;
  logic             err_r, err_s;
  logic             load_ops_s;
  logic             wr_en_s;
  logic [DW-1:0]    wr_idx_s;
  logic [WIDTH-1:0] wr_data_s;
  logic [WIDTH-1:0] top_data_s, next_data_s;
  logic             full_s;

  assign full_s = (depth_r == DW'(DEPTH));

  rpn_stack_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en_s),
    .wr_idx    (wr_idx_s),
    .wr_data   (wr_data_s),
    .depth     (depth_r),
    .top_data  (top_data_s),
    .next_data (next_data_s)
  );

  // Next-state, depth, error and write-port decode
  always_comb begin
    state_s    = state_r;
    depth_s    = depth_r;
    err_s      = err_r;
    load_ops_s = 1'b0;
    wr_en_s    = 1'b0;
    wr_idx_s   = depth_r;
    wr_data_s  = bus.data_i;
    case (state_r)
      IDLE: begin
        if (bus.op_start_i) begin
          // Operator wins over a simultaneous push, which is flagged
          if (depth_r >= DW'(2)) begin
            depth_s    = depth_r - DW'(2);
            state_s    = REQ;
            load_ops_s = 1'b1;
            err_s      = err_r | bus.push_i;
          end else begin
            err_s = 1'b1;
          end
        end else if (bus.push_i) begin
          if (full_s) begin
            err_s = 1'b1;
          end else begin
            wr_en_s = 1'b1;
            depth_s = depth_r + DW'(1);
          end
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (bus.push_i || bus.op_start_i) begin
          err_s = 1'b1;
        end else begin
          err_s = err_r;
        end
        // Result reuses a slot freed by the pop, so it can never overflow
        if (bus.res_valid_i) begin
          wr_en_s   = 1'b1;
          wr_data_s = bus.res_i;
          depth_s   = depth_r + DW'(1);
          state_s   = IDLE;
        end else begin
          state_s = REQ;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    if (bus.clear_i) begin
      wr_en_s = 1'b0;
    end else begin
      wr_en_s = wr_en_s;
    end
  end

  // Control state, depth, operand and flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      depth_r  <= '0;
      op_a_r   <= '0;
      op_b_r   <= '0;
      op_req_r <= 1'b0;
      err_r    <= 1'b0;
    end else if (bus.clear_i) begin
      state_r  <= IDLE;
      depth_r  <= '0;
      op_req_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      depth_r  <= depth_s;
      op_req_r <= (state_s == REQ);
      err_r    <= err_s;
      if (load_ops_s) begin
        op_a_r <= next_data_s;
        op_b_r <= top_data_s;
      end
    end
  end

  assign bus.operand_a_o = op_a_r;
  assign bus.operand_b_o = op_b_r;
  assign bus.op_req_o    = op_req_r;
  assign bus.top_o       = top_data_s;
  assign bus.depth_o     = depth_r;
  assign bus.empty_o     = (depth_r == DW'(0));
  assign bus.full_o      = full_s;
  assign bus.busy_o      = (state_r != IDLE);
  assign bus.err_o       = err_r;

endmodule
